cpu_step_ctrl: RTL and testbench

Execution controller between the slow-clock divider and the single-cycle processor core. It converts the divider's slow square wave into one-`clk`-wide clock-enable pulses for the core. Run/pause is selected by a switch, single-step by a debounced push-button, and the block stops permanently when the core reports halt. It also counts executed instructions for the seven-segment/LED debug display.

---
 rtl/cpu_step_ctrl.sv | 145 ++++++++++++++
 tb/tb_cpu_step_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_ctrl.sv
// Execution controller: turns the slow divider clock into single-cycle core enables,
// with free-run, debounced single-step, permanent halt and an executed-instruction count.
module cpu_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt,
  output logic             cpu_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [1:0]       state
);

  localparam int unsigned DebW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DebW-1:0] DebMax = DebW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StStep   = 2'b10,
    StHalted = 2'b11
  } state_e;

  // Two-flop synchronizers plus the slow-clock edge delay flop
  logic slow_meta_q, slow_s_q, slow_d_q;
  logic run_meta_q, run_s_q;
  logic step_meta_q, step_s_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slow_meta_q <= 1'b0;
      slow_s_q    <= 1'b0;
      slow_d_q    <= 1'b0;
      run_meta_q  <= 1'b0;
      run_s_q     <= 1'b0;
      step_meta_q <= 1'b0;
      step_s_q    <= 1'b0;
    end else begin
      slow_meta_q <= slow_clk;
      slow_s_q    <= slow_meta_q;
      slow_d_q    <= slow_s_q;
      run_meta_q  <= run_sw;
      run_s_q     <= run_meta_q;
      step_meta_q <= step_btn;
      step_s_q    <= step_meta_q;
    end
  end

  logic tick;
  assign tick = slow_s_q & ~slow_d_q;

  // Debounce: accept a new button level only after it differs for DEBOUNCE_CYCLES cycles
  logic            deb_q, deb_d, deb_dly_q;
  logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
  logic            step_req;

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (step_s_q != deb_q) begin
      if (deb_cnt_q == DebMax) begin
        deb_d = step_s_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DebW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign step_req = deb_q & ~deb_dly_q;

  // Control FSM
  state_e             state_q, state_d;
  logic               cpu_en_q, cpu_en_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    if (halt) begin
      state_d = StHalted;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run_s_q) begin
            state_d = StRun;
          end else if (step_req) begin
            state_d = StStep;
          end
        end
        StRun: begin
          if (!run_s_q) begin
            state_d = StIdle;
          end else if (tick) begin
            cpu_en_d = 1'b1;
          end
        end
        StStep: begin
          if (tick) begin
            cpu_en_d = 1'b1;
            state_d  = StIdle;
          end
        end
        StHalted: begin
          state_d = StHalted;
        end
      endcase
    end
  end

  // The count advances together with the enable it accounts for
  assign cnt_d = cpu_en_d ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cpu_en_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cpu_en_q <= cpu_en_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cpu_en    = cpu_en_q;
  assign cycle_cnt = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: edge-history behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cpu_step_ctrl;

  localparam int unsigned Deb  = 4;
  localparam int unsigned CntW = 4;

  logic            clk;
  logic            rst;
  logic            slow_clk;
  logic            run_sw;
  logic            step_btn;
  logic            halt;
  logic            cpu_en;
  logic [CntW-1:0] cycle_cnt;
  logic [1:0]      state;

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(Deb),
    .CNT_W          (CntW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .slow_clk (slow_clk),
    .run_sw   (run_sw),
    .step_btn (step_btn),
    .halt     (halt),
    .cpu_en   (cpu_en),
    .cycle_cnt(cycle_cnt),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw input samples per edge ([0] newest), an accepted button level that
  // flips after Deb consecutive differing edges, and the mode rules.
  bit [2:0] m_slow_h, m_run_h, m_step_h;
  bit       m_deb, m_deb_p;
  int       m_diff;
  int       m_state;
  bit       m_en;
  int       m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_slow_h = '0; m_run_h = '0; m_step_h = '0;
      m_deb = 0; m_deb_p = 0; m_diff = 0;
      m_state = 0; m_en = 0; m_cnt = 0;
    end else begin
      bit tick, run_s, step_s, req;
      tick   = m_slow_h[1] & ~m_slow_h[2];
      run_s  = m_run_h[1];
      step_s = m_step_h[1];
      req    = m_deb & ~m_deb_p;
      m_en   = 0;
      if (halt) m_state = 3;
      else begin
        case (m_state)
          0: if (run_s) m_state = 1; else if (req) m_state = 2;
          1: if (!run_s) m_state = 0; else if (tick) m_en = 1;
          2: if (tick) begin m_en = 1; m_state = 0; end
          default: ;
        endcase
      end
      if (m_en) m_cnt = (m_cnt + 1) % (1 << CntW);
      m_deb_p = m_deb;
      if (step_s != m_deb) begin
        m_diff++;
        if (m_diff == Deb) begin
          m_deb  = step_s;
          m_diff = 0;
        end
      end else m_diff = 0;
      m_slow_h = {m_slow_h[1:0], slow_clk};
      m_run_h  = {m_run_h[1:0], run_sw};
      m_step_h = {m_step_h[1:0], step_btn};
    end
  end

  logic prev_en = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("cpu_en", cpu_en, m_en);
      chk("cycle_cnt", cycle_cnt, m_cnt);
      chk("state", state, m_state);
      chk("no_back_to_back", cpu_en & prev_en, 0);
      if (cpu_en === 1'b1) pulses++;
      prev_en = cpu_en;
    end else prev_en = 1'b0;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; slow_clk = 0; run_sw = 0; step_btn = 0; halt = 0;
    cyc(2);
    chk("reset_state", state, 0);
    chk("reset_cnt", cycle_cnt, 0);
    chk("reset_en", cpu_en, 0);
    rst = 0;
  endtask

  // One 20-cycle slow period from a negedge; checks the pulse lands on the 3rd edge.
  task automatic slow_period(input bit exp_pulse);
    slow_clk = 1;
    @(posedge clk); #1 chk("edge1_quiet", cpu_en, 0);
    @(posedge clk); #1 chk("edge2_quiet", cpu_en, 0);
    @(posedge clk); #1 chk("edge3_pulse", cpu_en, exp_pulse);
    @(posedge clk); #1 chk("edge4_quiet", cpu_en, 0);
    cyc(7);
    slow_clk = 0;
    cyc(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst = 1; slow_clk = 0; run_sw = 0; step_btn = 0; halt = 0;

    // Free run: 5 ticks -> 5 pulses
    do_reset();
    run_sw = 1; cyc(4);
    chk("t1_run_state", state, 1);
    p0 = pulses;
    repeat (5) slow_period(1);
    chk("t1_pulses", pulses - p0, 5);
    chk("t1_cnt", cycle_cnt, 5);
    chk("t1_state", state, 1);

    // Bouncing step press, then a second press while waiting in STEP
    do_reset();
    cyc(2);
    step_btn = 1; cyc(1); step_btn = 0; cyc(1);
    step_btn = 1; cyc(1); step_btn = 0; cyc(1);
    step_btn = 1; cyc(11);
    chk("t2_in_step", state, 2);
    step_btn = 0; cyc(8);
    step_btn = 1; cyc(8);
    step_btn = 0; cyc(8);
    chk("t2_still_step", state, 2);
    p0 = pulses;
    slow_period(1);
    chk("t2_back_idle", state, 0);
    slow_period(0);
    slow_period(0);
    chk("t2_pulses", pulses - p0, 1);
    chk("t2_cnt", cycle_cnt, 1);

    // Halt coincident with tick wins
    do_reset();
    run_sw = 1; cyc(4);
    p0 = pulses;
    slow_clk = 1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); halt = 1;
    @(posedge clk); #1;
    chk("t3_halt_no_pulse", cpu_en, 0);
    chk("t3_halted", state, 3);
    @(negedge clk); halt = 0;
    cyc(7); slow_clk = 0; cyc(10);
    slow_period(0);
    slow_period(0);
    step_btn = 1; cyc(12); step_btn = 0; cyc(8);
    run_sw = 0; cyc(4); run_sw = 1; cyc(4);
    chk("t3_stays_halted", state, 3);
    chk("t3_pulses", pulses - p0, 0);

    // Pause lands on the same edge as a tick
    do_reset();
    run_sw = 1; cyc(4);
    p0 = pulses;
    run_sw = 0; slow_clk = 1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    chk("t4_no_pulse", cpu_en, 0);
    chk("t4_idle", state, 0);
    cyc(8); slow_clk = 0; cyc(5);
    run_sw = 1; cyc(5);
    chk("t4_rerun", state, 1);
    repeat (2) slow_period(1);
    chk("t4_pulses", pulses - p0, 2);
    chk("t4_cnt", cycle_cnt, 2);

    // Counter wrap, then async reset in the middle of a pulse
    do_reset();
    run_sw = 1; cyc(4);
    repeat (15) slow_period(1);
    chk("t5_cnt15", cycle_cnt, 15);
    slow_period(1);
    chk("t5_cnt0", cycle_cnt, 0);
    slow_period(1);
    chk("t5_cnt1", cycle_cnt, 1);
    slow_clk = 1;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1 chk("t5_pulse_before_rst", cpu_en, 1);
    #1 rst = 1;
    #1;
    chk("t5_rst_en", cpu_en, 0);
    chk("t5_rst_cnt", cycle_cnt, 0);
    chk("t5_rst_state", state, 0);
    @(negedge clk); rst = 0;
    cyc(3); slow_clk = 0; cyc(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
